// File: rtl/link_arbiter_pkg.sv
// Shared definitions for the two-client Req/Ack link arbiter.
package link_arbiter_pkg;

  localparam int NUM_CLIENTS = 2;
  localparam int DATA_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/link_arbiter_if.sv
// Link bundle between the arbiter (master) and its senders/receiver (slave).
interface link_arbiter_if #(
  parameter int DATA_W = link_arbiter_pkg::DATA_W_DEF
);

  logic [1:0]        TxReq;
  logic [1:0]        Transmit;
  logic [1:0]        Ready;
  logic [1:0]        ReqIn;
  logic [DATA_W-1:0] DataIn0;
  logic [DATA_W-1:0] DataIn1;
  logic [1:0]        AckOut;
  logic              ReqOut;
  logic [DATA_W-1:0] DataOut;
  logic              AckIn;
  logic [1:0]        Grant;
  logic              Busy;
  logic              Done;
  logic              Error;

  modport master (
    input  TxReq, Ready, ReqIn, DataIn0, DataIn1, AckIn,
    output Transmit, AckOut, ReqOut, DataOut, Grant, Busy, Done, Error
  );

  modport slave (
    output TxReq, Ready, ReqIn, DataIn0, DataIn1, AckIn,
    input  Transmit, AckOut, ReqOut, DataOut, Grant, Busy, Done, Error
  );

endinterface

// File: rtl/link_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin pick; ptr selects the favoured client on a tie.
module rr_arbiter2
  import link_arbiter_pkg::*;
(
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic                   ptr,
  output logic [NUM_CLIENTS-1:0] grant
);

  always_comb begin
    // NOTE: assign every always_comb output before any branch so no path leaves it unassigned and infers a latch.
    grant = req;
    if (&req) grant = ptr ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/link_arbiter.sv
// Shares one 4-phase Req/Ack link between two frame senders; grant is held
// for a whole frame and released once the last handshake has fully returned to zero.
module link_arbiter
  import link_arbiter_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic          Clock,
  input  logic          Reset,
  link_arbiter_if.master bus
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [1:0]        grant_q, grant_d, arb_grant;
  logic              ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              done_q, done_d, error_q, error_d;
  logic              g, routed, req_sel, ready_g, timeout_hit;
  logic [DATA_W-1:0] data_sel;

  rr_arbiter2 u_arb (
    .req   (bus.TxReq),
    .ptr   (ptr_q),
    .grant (arb_grant)
  );

  // Owner index; grant_q is one-hot whenever it matters.
  assign g           = grant_q[1];
  assign routed      = (state_q == XFER) || (state_q == DRAIN);
  assign req_sel     = bus.ReqIn[g];
  assign data_sel    = g ? bus.DataIn1 : bus.DataIn0;
  assign ready_g     = bus.Ready[g];
  assign timeout_hit = (cnt_q == CNT_LAST);

  always_ff @(posedge Clock or posedge Reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (Reset) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    error_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.TxReq) begin
          grant_d = arb_grant;
          state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = XFER;
      end
      XFER: begin
        cnt_d = cnt_q + CW'(1);
        // Ready takes precedence when it lands on the final timeout cycle.
        if (ready_g) begin
          done_d  = 1'b1;
          ptr_d   = ~g;
          state_d = DRAIN;
        end else if (timeout_hit) begin
          error_d = 1'b1;
          ptr_d   = ~g;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!req_sel && !bus.AckIn) begin
          grant_d = 2'b00;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.Transmit = (state_q == START) ? grant_q : 2'b00;
  assign bus.ReqOut   = routed & req_sel;
  assign bus.DataOut  = routed ? data_sel : '0;
  assign bus.AckOut   = routed ? (grant_q & {2{bus.AckIn}}) : 2'b00;
  assign bus.Grant    = grant_q;
  assign bus.Busy     = (state_q != IDLE);
  assign bus.Done     = done_q;
  assign bus.Error    = error_q;

endmodule

// File: tb/tb_link_arbiter.sv
// Bench for link_arbiter: a full-timeout instance carries real frames through a
// receiver model with a scoreboard; a TIMEOUT=8 instance exercises the abort path.
module tb_link_arbiter;
  import link_arbiter_pkg::*;

  localparam int DW = 16;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  link_arbiter_if #(.DATA_W(DW)) bus   ();
  link_arbiter_if #(.DATA_W(DW)) bus_t ();

  link_arbiter #(.DATA_W(DW), .TIMEOUT(255)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  link_arbiter #(.DATA_W(DW), .TIMEOUT(8)) dut_t (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus_t)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic [DW-1:0] sb[$];
  bit iso_run;

  function automatic logic [DW-1:0] pat(input int c, input int f, input int w);
    return DW'(32'h1000 * (c + 1) + 32'h100 * f + w);
  endfunction

  function automatic logic [25:0] outs_main();
    return {bus.Transmit, bus.AckOut, bus.ReqOut, bus.DataOut,
            bus.Grant, bus.Busy, bus.Done, bus.Error};
  endfunction

  function automatic logic [25:0] outs_t();
    return {bus_t.Transmit, bus_t.AckOut, bus_t.ReqOut, bus_t.DataOut,
            bus_t.Grant, bus_t.Busy, bus_t.Done, bus_t.Error};
  endfunction

  // Receiver model: accepts a word when Req rises, completes 4-phase when Req falls.
  initial begin
    logic [DW-1:0] exp_w;
    bus.AckIn = 1'b0;
    forever begin
      @(posedge Clock);
      #1;
      if (Reset) begin
        bus.AckIn = 1'b0;
      end else if (bus.ReqOut && !bus.AckIn) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL rx_word: got %h, expected no word", bus.DataOut);
        end else begin
          exp_w = sb.pop_front();
          if (bus.DataOut !== exp_w) begin
            miscompares++;
            $display("FAIL rx_word: got %h, want %h", bus.DataOut, exp_w);
          end
        end
        bus.AckIn = 1'b1;
      end else if (!bus.ReqOut && bus.AckIn) begin
        bus.AckIn = 1'b0;
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic wait_ack(input int c, input logic lvl);
    int k;
    k = 0;
    do begin
      @(negedge Clock);
      k++;
    end while (bus.AckOut[c] !== lvl && k < 20);
    vectors++;
    if (bus.AckOut[c] !== lvl) begin
      miscompares++;
      $display("FAIL ack_wait c%0d: got %b, want %b", c, bus.AckOut[c], lvl);
    end
  endtask

  task automatic send_words(input int c, input int f, input int n);
    logic [DW-1:0] d;
    for (int w = 0; w < n; w++) begin
      d = pat(c, f, w);
      if (c == 0) bus.DataIn0 = d;
      else        bus.DataIn1 = d;
      sb.push_back(d);
      bus.ReqIn[c] = 1'b1;
      wait_ack(c, 1'b1);
      bus.ReqIn[c] = 1'b0;
      wait_ack(c, 1'b0);
    end
  endtask

  // Called on the negedge right after the grant edge; returns one cycle after DRAIN exits.
  task automatic serve(input int c, input int f);
    logic [1:0] oh;
    oh = 2'(1 << c);
    vectors++;
    if (bus.Grant !== oh || bus.Transmit !== oh) begin
      miscompares++;
      $display("FAIL start c%0d: got grant=%b transmit=%b, want %b/%b",
               c, bus.Grant, bus.Transmit, oh, oh);
    end
    @(negedge Clock);
    vectors++;
    if (bus.Transmit !== 2'b00 || bus.Busy !== 1'b1) begin
      miscompares++;
      $display("FAIL xfer_entry c%0d: got transmit=%b busy=%b, want 00/1",
               c, bus.Transmit, bus.Busy);
    end
    send_words(c, f, 16);
    bus.Ready[c] = 1'b1;
    @(negedge Clock);
    bus.Ready[c] = 1'b0;
    bus.TxReq[c] = 1'b0;
    vectors++;
    if ({bus.Done, bus.Error, bus.Grant} !== {1'b1, 1'b0, oh}) begin
      miscompares++;
      $display("FAIL frame_done c%0d: got done=%b err=%b grant=%b, want 1/0/%b",
               c, bus.Done, bus.Error, bus.Grant, oh);
    end
    @(negedge Clock);
    vectors++;
    if ({bus.Done, bus.Busy, bus.Grant} !== 4'b0000) begin
      miscompares++;
      $display("FAIL drain_exit c%0d: got done=%b busy=%b grant=%b, want 0/0/00",
               c, bus.Done, bus.Busy, bus.Grant);
    end
  endtask

  task automatic test_reset;
    @(negedge Clock);
    vectors++;
    if (outs_main() !== 26'd0) begin
      miscompares++;
      $display("FAIL reset_main: got %h, want 0", outs_main());
    end
    vectors++;
    if (outs_t() !== 26'd0) begin
      miscompares++;
      $display("FAIL reset_t: got %h, want 0", outs_t());
    end
    Reset = 1'b0;
    @(negedge Clock);
  endtask

  task automatic test_both;
    bus.TxReq = 2'b11;
    @(negedge Clock);
    serve(0, 0);
    @(negedge Clock);
    serve(1, 0);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL both_drain: got %0d undelivered words, want 0", sb.size());
    end
  endtask

  task automatic test_single;
    bus.TxReq = 2'b01;
    @(negedge Clock);
    serve(0, 1);
  endtask

  task automatic test_isolation;
    bus.DataIn1 = 16'hBEEF;
    bus.TxReq   = 2'b01;
    iso_run     = 1'b1;
    @(negedge Clock);
    fork
      begin
        serve(0, 2);
        iso_run = 1'b0;
      end
      begin
        while (iso_run) begin
          @(negedge Clock);
          bus.ReqIn[1] = ~bus.ReqIn[1];
          #1;
          vectors++;
          if (bus.ReqOut !== (bus.ReqIn[0] & dut.routed) || bus.DataOut === 16'hBEEF
              || bus.AckOut[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL isolation: got req=%b data=%h ack1=%b", bus.ReqOut,
                     bus.DataOut, bus.AckOut[1]);
          end
        end
      end
    join
    bus.ReqIn[1] = 1'b0;
    bus.DataIn1  = '0;
  endtask

  task automatic test_timeout;
    bus_t.TxReq = 2'b11;
    @(negedge Clock);
    vectors++;
    if (bus_t.Grant !== 2'b01 || bus_t.Transmit !== 2'b01) begin
      miscompares++;
      $display("FAIL to_start: got grant=%b transmit=%b, want 01/01",
               bus_t.Grant, bus_t.Transmit);
    end
    for (int k = 2; k <= 9; k++) begin
      @(negedge Clock);
      bus_t.Ready[1] = (k == 4);
      vectors++;
      if (bus_t.Error !== 1'b0 || bus_t.Done !== 1'b0) begin
        miscompares++;
        $display("FAIL to_early k%0d: got err=%b done=%b, want 0/0", k, bus_t.Error, bus_t.Done);
      end
    end
    @(negedge Clock);
    vectors++;
    if (bus_t.Error !== 1'b1 || bus_t.Done !== 1'b0) begin
      miscompares++;
      $display("FAIL to_abort: got err=%b done=%b, want 1/0", bus_t.Error, bus_t.Done);
    end
    bus_t.TxReq[0] = 1'b0;
    @(negedge Clock);
    vectors++;
    if (bus_t.Error !== 1'b0 || bus_t.Grant !== 2'b00) begin
      miscompares++;
      $display("FAIL to_release: got err=%b grant=%b, want 0/00", bus_t.Error, bus_t.Grant);
    end
    @(negedge Clock);
    vectors++;
    if (bus_t.Grant !== 2'b10 || bus_t.Transmit !== 2'b10) begin
      miscompares++;
      $display("FAIL to_handover: got grant=%b transmit=%b, want 10/10",
               bus_t.Grant, bus_t.Transmit);
    end
  endtask

  // Continues from test_timeout: client 1 is in START on the timeout instance.
  task automatic test_coincide;
    for (int k = 0; k < 8; k++) @(negedge Clock);
    bus_t.Ready[1] = 1'b1;
    @(negedge Clock);
    bus_t.Ready[1] = 1'b0;
    bus_t.TxReq    = 2'b00;
    vectors++;
    if (bus_t.Done !== 1'b1 || bus_t.Error !== 1'b0) begin
      miscompares++;
      $display("FAIL coincide: got done=%b err=%b, want 1/0", bus_t.Done, bus_t.Error);
    end
  endtask

  task automatic test_reset_mid;
    logic [DW-1:0] d;
    bus.TxReq = 2'b01;
    @(negedge Clock);
    @(negedge Clock);
    send_words(0, 3, 4);
    d = pat(0, 3, 4);
    bus.DataIn0  = d;
    sb.push_back(d);
    bus.ReqIn[0] = 1'b1;
    #1;
    vectors++;
    if (bus.ReqOut !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_req: got %b, want 1", bus.ReqOut);
    end
    Reset = 1'b1;
    #1;
    vectors++;
    if (outs_main() !== 26'd0) begin
      miscompares++;
      $display("FAIL mid_reset_async: got %h, want 0", outs_main());
    end
    sb.delete();
    bus.ReqIn = 2'b00;
    bus.TxReq = 2'b00;
    bus.DataIn0 = '0;
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    // Client 0 finished last before reset; a tie must still go to client 0.
    bus.TxReq = 2'b11;
    @(negedge Clock);
    vectors++;
    if (bus.Grant !== 2'b01) begin
      miscompares++;
      $display("FAIL ptr_after_reset: got %b, want 01", bus.Grant);
    end
    bus.TxReq = 2'b00;
  endtask

  initial begin
    bus.TxReq   = 2'b00;
    bus.Ready   = 2'b00;
    bus.ReqIn   = 2'b00;
    bus.DataIn0 = '0;
    bus.DataIn1 = '0;
    bus_t.TxReq   = 2'b00;
    bus_t.Ready   = 2'b00;
    bus_t.ReqIn   = 2'b00;
    bus_t.DataIn0 = '0;
    bus_t.DataIn1 = '0;
    bus_t.AckIn   = 1'b0;
    iso_run       = 1'b0;
    test_reset();
    test_both();
    test_single();
    test_isolation();
    test_timeout();
    test_coincide();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
